// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder for the RV32I core data bus. Word-organised
//            RAM with byte-lane writes, a programmable number of wait states,
//            a one-cycle ready strobe and an error qualifier for out-of-window
//            or malformed (write+read) requests.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH_WORDS = 1024,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int               WAIT_STATES = 0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_bus_addr,
  input  logic [WIDTH-1:0] i_bus_wdata,
  input  logic [3:0]       i_bus_byteen,
  input  logic             i_bus_we,
  input  logic             i_bus_re,
  output logic [WIDTH-1:0] o_bus_rdata,
  output logic             o_bus_ready,
  output logic             o_bus_err
);

  localparam int               c_AW    = $clog2(DEPTH_WORDS);
  localparam int               c_LANES = 4;
  localparam logic [3:0]       c_WS    = 4'(WAIT_STATES);
  localparam logic [WIDTH-1:0] c_BASE  = BASE_ADDR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Storage: not reset, contents undefined until written by the requester.
  logic [WIDTH-1:0] ram [DEPTH_WORDS];

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_err_q, pend_err_d;
  logic             pend_rd_q, pend_rd_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             w_req;
  logic             w_accept;
  logic             w_in_range;
  logic             w_req_err;
  logic             w_wr_commit;
  logic [c_AW-1:0]  w_idx;
  logic [WIDTH-1:0] w_ram_word;
  logic             w_go_resp;
  logic             w_resp_err;
  logic             w_resp_rd;
  logic [WIDTH-1:0] w_resp_data;
  logic             w_unused;

  // Byte offset within a word never affects the access.
  assign w_unused = ^i_bus_addr[1:0];

  // Window decode: BASE_ADDR is aligned to the window size, so the upper
  // address bits alone decide membership and no wrap-around can occur.
  assign w_req       = i_bus_we | i_bus_re;
  assign w_accept    = (state_q == ST_IDLE) && w_req;
  assign w_in_range  = (i_bus_addr[WIDTH-1:c_AW+2] == c_BASE[WIDTH-1:c_AW+2]);
  assign w_idx       = i_bus_addr[c_AW+1:2];
  assign w_req_err   = !w_in_range || (i_bus_we && i_bus_re);
  assign w_ram_word  = ram[w_idx];
  // Gating with reset keeps a request presented during reset from touching RAM.
  assign w_wr_commit = w_accept && i_reset_n && i_bus_we && !i_bus_re && w_in_range;

  // Byte-lane RAM write at the accept edge.
  always_ff @(posedge i_clk) begin
    if (w_wr_commit) begin
      for (int k = 0; k < c_LANES; k++) begin
        if (i_bus_byteen[k]) begin
          ram[w_idx][8*k +: 8] <= i_bus_wdata[8*k +: 8];
        end
      end
    end
  end

  // Next-state logic: capture request, count wait states, schedule response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_err_d  = pend_err_q;
    pend_rd_d   = pend_rd_q;
    pend_data_d = pend_data_q;
    w_go_resp   = 1'b0;
    w_resp_err  = pend_err_q;
    w_resp_rd   = pend_rd_q;
    w_resp_data = pend_data_q;

    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          pend_err_d  = w_req_err;
          pend_rd_d   = i_bus_re;
          pend_data_d = w_ram_word;
          if (c_WS == 4'd0) begin
            w_go_resp   = 1'b1;
            w_resp_err  = w_req_err;
            w_resp_rd   = i_bus_re;
            w_resp_data = w_ram_word;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = c_WS - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          w_go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_go_resp) begin
      state_d = ST_RESP;
    end
  end

  // Registered response outputs; read data only changes on a read response.
  always_comb begin
    ready_d = w_go_resp;
    err_d   = w_go_resp && w_resp_err;
    rdata_d = rdata_q;
    if (w_go_resp && w_resp_rd) begin
      rdata_d = w_resp_err ? '0 : w_resp_data;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pend_err_q  <= 1'b0;
      pend_rd_q   <= 1'b0;
      pend_data_q <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_err_q  <= pend_err_d;
      pend_rd_q   <= pend_rd_d;
      pend_data_q <= pend_data_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_bus_rdata = rdata_q;
  assign o_bus_ready = ready_q;
  assign o_bus_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder. Two instances (zero and
//            three wait states) are exercised against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          D    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        we    [2];
  logic        re    [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int ws [2] = '{0, 3};
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] mdl    [2][D];
  logic [31:0] mdl_rd [2];
  bit          rd_known [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(D), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_bus_addr(addr[0]), .i_bus_wdata(wdata[0]),
    .i_bus_byteen(be[0]), .i_bus_we(we[0]), .i_bus_re(re[0]),
    .o_bus_rdata(rdata[0]), .o_bus_ready(ready[0]), .o_bus_err(err[0]));

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(D), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_bus_addr(addr[1]), .i_bus_wdata(wdata[1]),
    .i_bus_byteen(be[1]), .i_bus_we(we[1]), .i_bus_re(re[1]),
    .o_bus_rdata(rdata[1]), .o_bus_ready(ready[1]), .o_bus_err(err[1]));

  // ---------------- reference model ----------------
  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * D)));
  endfunction

  task automatic mdl_apply(input int s, input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b, output bit exp_err);
    int idx;
    exp_err = !in_rng(a) || (w && r);
    idx = int'((a - BASE) >> 2);
    if (!exp_err && w) begin
      for (int k = 0; k < 4; k++) if (b[k]) mdl[s][idx][8*k +: 8] = d[8*k +: 8];
    end
    if (r && !w) begin
      mdl_rd[s]   = exp_err ? 32'h0 : mdl[s][idx];
      rd_known[s] = 1'b1;
    end
    if (r && w) rd_known[s] = 1'b0;
  endtask

  // One bus transaction: drive, wait (bounded) for ready, release, confirm strobe width.
  task automatic do_access(input int s, input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           output logic [31:0] rd, output logic er, output int lat, output bit one);
    @(negedge clk);
    addr[s] = a; wdata[s] = d; be[s] = b; we[s] = w; re[s] = r;
    lat = 0; rd = '0; er = 1'b0; one = 1'b0;
    do begin
      @(posedge clk); #1; lat++;
    end while (ready[s] !== 1'b1 && lat < 40);
    rd = rdata[s];
    er = err[s];
    we[s] = 1'b0; re[s] = 1'b0;
    @(posedge clk); #1;
    one = (ready[s] === 1'b0) && (lat < 40);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; wdata[s] = '0; be[s] = '0; we[s] = 1'b0; re[s] = 1'b0;
      mdl_rd[s] = '0; rd_known[s] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (ready[s] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d got %b want 0", s, ready[s]); end
      checks++; if (err[s] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %b want 0", s, err[s]); end
      checks++; if (rdata[s] !== 32'h0) begin errors++; $display("FAIL reset_rdata dut%0d got %h want 0", s, rdata[s]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [31:0] rd; logic er; int lat; bit one; bit e;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < D; i++) begin
        logic [31:0] v;
        v = $urandom;
        do_access(s, 1'b1, 1'b0, BASE + 32'(i * 4), v, 4'hF, rd, er, lat, one);
        mdl_apply(s, 1'b1, 1'b0, BASE + 32'(i * 4), v, 4'hF, e);
        checks++; if (er !== e) begin errors++; $display("FAIL init_err dut%0d word %0d got %b want %b", s, i, er, e); end
      end
    end
  endtask

  typedef struct {
    bit w; bit r; logic [31:0] a; logic [31:0] d; logic [3:0] b;
    bit e; bit chk; bit use_m; logic [31:0] x;
  } row_t;

  task automatic test_directed();
    row_t tbl [12];
    logic [31:0] rd; logic [31:0] xp; logic er; int lat; bit one; bit e;
    tbl = '{
      '{1, 0, BASE + 32'h10,    32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0},
      '{0, 1, BASE + 32'h10,    32'h0,        4'h0, 0, 1, 0, 32'hDEADBEEF},
      '{1, 0, BASE + 32'h10,    32'h0000AB00, 4'h2, 0, 0, 0, 32'h0},
      '{0, 1, BASE + 32'h10,    32'h0,        4'h0, 0, 1, 0, 32'hDEADABEF},
      '{1, 0, BASE + 32'h10,    32'hFFFFFFFF, 4'h0, 0, 0, 0, 32'h0},
      '{0, 1, BASE + 32'h10,    32'h0,        4'h0, 0, 1, 0, 32'hDEADABEF},
      '{1, 0, BASE + 32'(4*D),  32'h11111111, 4'hF, 1, 0, 0, 32'h0},
      '{1, 0, BASE - 32'h4,     32'h22222222, 4'hF, 1, 0, 0, 32'h0},
      '{0, 1, BASE,             32'h0,        4'h0, 0, 1, 1, 32'h0},
      '{0, 1, BASE + 32'(4*D),  32'h0,        4'h0, 1, 1, 0, 32'h0},
      '{1, 1, BASE,             32'h33333333, 4'hF, 1, 0, 0, 32'h0},
      '{0, 1, BASE,             32'h0,        4'h0, 0, 1, 1, 32'h0}
    };
    for (int i = 0; i < 12; i++) begin
      xp = tbl[i].use_m ? mdl[0][0] : tbl[i].x;
      do_access(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].b, rd, er, lat, one);
      mdl_apply(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].b, e);
      checks++; if (er !== tbl[i].e) begin errors++; $display("FAIL dir_err step %0d got %b want %b", i, er, tbl[i].e); end
      checks++; if (lat != 1) begin errors++; $display("FAIL dir_latency step %0d got %0d want 1", i, lat); end
      checks++; if (!one) begin errors++; $display("FAIL dir_strobe step %0d ready not a single cycle", i); end
      if (tbl[i].chk) begin
        checks++; if (rd !== xp) begin errors++; $display("FAIL dir_rdata step %0d got %h want %h", i, rd, xp); end
      end
    end
  endtask

  task automatic test_back_to_back(input int s);
    int t_acc; int t_rdy [3]; logic [31:0] dv [3]; int n; int guard; logic [31:0] xp;
    n = 0; guard = 0;
    xp = mdl[s][12];
    @(negedge clk);
    addr[s] = BASE + 32'(12 * 4) + 32'd3; we[s] = 1'b0; re[s] = 1'b1; be[s] = 4'h0;
    @(posedge clk); #1;
    t_acc = cyc;
    while (n < 3 && guard < 60) begin
      if (ready[s] === 1'b1) begin
        t_rdy[n] = cyc; dv[n] = rdata[s]; n++;
        addr[s] = BASE + 32'(12 * 4);
      end
      if (n < 3) begin @(posedge clk); #1; guard++; end
    end
    re[s] = 1'b0;
    @(posedge clk); #1;
    mdl_rd[s] = xp; rd_known[s] = 1'b1;
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count dut%0d got %0d want 3", s, n); end
    if (n == 3) begin
      checks++; if (t_rdy[0] != t_acc + ws[s]) begin errors++; $display("FAIL b2b_first dut%0d got %0d want %0d", s, t_rdy[0] - t_acc, ws[s]); end
      for (int i = 1; i < 3; i++) begin
        checks++; if (t_rdy[i] - t_rdy[i-1] != ws[s] + 2) begin errors++; $display("FAIL b2b_spacing dut%0d got %0d want %0d", s, t_rdy[i] - t_rdy[i-1], ws[s] + 2); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (dv[i] !== xp) begin errors++; $display("FAIL b2b_rdata dut%0d resp %0d got %h want %h", s, i, dv[i], xp); end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat; bit one; bit e; logic [31:0] x; logic [31:0] y; int seen;
    do_access(1, 1'b1, 1'b0, BASE + 32'(5 * 4), 32'hA5A50001, 4'hF, rd, er, lat, one);
    mdl_apply(1, 1'b1, 1'b0, BASE + 32'(5 * 4), 32'hA5A50001, 4'hF, e);
    do_access(1, 1'b0, 1'b1, BASE + 32'(5 * 4), 32'h0, 4'h0, rd, er, lat, one);
    mdl_apply(1, 1'b0, 1'b1, BASE + 32'(5 * 4), 32'h0, 4'h0, e);
    checks++; if (rd !== 32'hA5A50001) begin errors++; $display("FAIL midop_pre_rdata got %h want a5a50001", rd); end
    // Read in flight, reset lands during its response cycle.
    @(negedge clk);
    addr[1] = BASE + 32'(7 * 4); re[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL midop_ready_before got %b want 1", ready[1]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready[1] !== 1'b0) begin errors++; $display("FAIL midop_async_ready got %b want 0", ready[1]); end
    checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL midop_async_err got %b want 0", err[1]); end
    checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL midop_async_rdata got %h want 0", rdata[1]); end
    re[1] = 1'b0;
    mdl_rd[0] = '0; mdl_rd[1] = '0; rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready[1] === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midop_dropped got %0d ready strobes want 0", seen); end
    // Write accepted just before reset must survive; one presented during reset must not.
    x = $urandom; y = $urandom;
    @(negedge clk);
    addr[1] = BASE + 32'(9 * 4); wdata[1] = x; be[1] = 4'hF; we[1] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    mdl[1][9] = x;
    we[1] = 1'b0;
    @(negedge clk);
    addr[1] = BASE + 32'(10 * 4); wdata[1] = y; we[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    we[1] = 1'b0;
    rst_n = 1'b1;
    do_access(1, 1'b0, 1'b1, BASE + 32'(9 * 4), 32'h0, 4'h0, rd, er, lat, one);
    mdl_apply(1, 1'b0, 1'b1, BASE + 32'(9 * 4), 32'h0, 4'h0, e);
    checks++; if (rd !== x) begin errors++; $display("FAIL midop_committed got %h want %h", rd, x); end
    checks++; if (lat != 4) begin errors++; $display("FAIL midop_latency got %0d want 4", lat); end
    do_access(1, 1'b0, 1'b1, BASE + 32'(10 * 4), 32'h0, 4'h0, rd, er, lat, one);
    mdl_apply(1, 1'b0, 1'b1, BASE + 32'(10 * 4), 32'h0, 4'h0, e);
    checks++; if (rd !== mdl[1][10]) begin errors++; $display("FAIL midop_uncommitted got %h want %h", rd, mdl[1][10]); end
  endtask

  task automatic test_random(input int s, input int n_ops);
    logic [31:0] rd; logic er; int lat; bit one; bit e; logic [31:0] a; logic [31:0] d;
    logic [3:0] b; bit w; bit r; int sel;
    for (int i = 0; i < n_ops; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = BASE - 32'h4 + 32'($urandom_range(0, 3));
        1: a = BASE + 32'(4 * D) + 32'($urandom_range(0, 3));
        2: a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 4 * D - 1));
      endcase
      sel = $urandom_range(0, 9);
      w = (sel == 0) || (sel >= 5);
      r = (sel <= 4);
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      do_access(s, w, r, a, d, b, rd, er, lat, one);
      mdl_apply(s, w, r, a, d, b, e);
      checks++; if (er !== e) begin errors++; $display("FAIL rand_err dut%0d op %0d addr %h got %b want %b", s, i, a, er, e); end
      checks++; if (lat != ws[s] + 1) begin errors++; $display("FAIL rand_latency dut%0d op %0d got %0d want %0d", s, i, lat, ws[s] + 1); end
      checks++; if (!one) begin errors++; $display("FAIL rand_strobe dut%0d op %0d ready not a single cycle", s, i); end
      if (rd_known[s]) begin
        checks++; if (rd !== mdl_rd[s]) begin errors++; $display("FAIL rand_rdata dut%0d op %0d addr %h got %h want %h", s, i, a, rd, mdl_rd[s]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_midop();
    test_random(0, 150);
    test_random(1, 120);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32I core's data bus. It accepts the byte-addressed read and write requests driven by the core's data-memory interface. It holds a word-organised RAM with byte-lane writes and returns read data with a single-cycle ready pulse after a configurable number of wait states. Out-of-window and malformed requests are flagged with an error response.

## Interface
- `WIDTH`, 32: data and address width.
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words (power of two).
- `BASE_ADDR`, 32'h1000_0000: byte address of word 0 (aligned to 4*DEPTH_WORDS).
- `WAIT_STATES`, 0: extra cycles between accept and response (0..15).

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_reset_n` in 1: reset, asynchronous assert, active-low.
- `i_bus_addr` in WIDTH: byte address.
- `i_bus_wdata` in WIDTH: write data, lane-aligned.
- `i_bus_byteen` in 4: byte-lane write enables; bit k selects bits [8k+7:8k].
- `i_bus_we` in 1: write request.
- `i_bus_re` in 1: read request.
- `o_bus_rdata` out WIDTH: full read word. Lane extraction and sign extension belong to the requester.
- `o_bus_ready` out 1: one-cycle response strobe.
- `o_bus_err` out 1: error qualifier, valid only while `o_bus_ready`=1.

## Operation
- States:
  - IDLE: accepts requests.
  - WAIT: counts wait states.
  - RESP: drives `o_bus_ready`.
- Accept: at a rising edge in IDLE with `i_bus_we|i_bus_re`=1. Request fields are captured at that edge.
- Transitions:
  - IDLE → WAIT when WAIT_STATES>0, else IDLE → RESP.
  - WAIT stays for exactly WAIT_STATES cycles, then → RESP.
  - RESP → IDLE unconditionally.
- Requests are ignored in WAIT and RESP. The requester holds its request stable until it sees `o_bus_ready`=1.
- Decode:
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR+4*DEPTH_WORDS.
  - Word index = (addr−BASE_ADDR)>>2.
  - addr[1:0] is ignored.
- Write, in range, `we`=1 and `re`=0:
  - Enabled lanes of the indexed word are updated at the accept edge.
  - Disabled lanes keep their value.
  - byteen=0000 is a legal no-op with an OK response.
- Read, in range, `re`=1 and `we`=0: the indexed word is captured at the accept edge and presented on `o_bus_rdata` from RESP onward.
- Error response (`o_bus_err`=1 in RESP, no RAM change) for either:
  - an out-of-range address, or
  - `we` and `re` both set.
- On an error read, `o_bus_rdata` is driven to 0.
- `o_bus_rdata` holds the last read response until the next read response. Writes do not alter it.
- The RAM array is not reset. Contents after power-up are undefined; the testbench initialises memory before reading it.

## Timing
- Reset values: `o_bus_ready`=0, `o_bus_err`=0, `o_bus_rdata`=0, state=IDLE, wait counter=0.
- Accept at edge N → `o_bus_ready`=1 during the cycle between edges N+WAIT_STATES and N+WAIT_STATES+1. The strobe is exactly one cycle.
- Throughput: one access per WAIT_STATES+2 cycles. With WAIT_STATES=0, back-to-back requests are accepted every 2nd edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously), and any response in flight is dropped.
  - A write whose accept edge has already occurred stays committed.
  - A request not yet accepted causes no RAM change.
- Reset deassertion is synchronised by the system. The first acceptance can occur at the first rising edge with `i_reset_n`=1.
- Write-then-read to the same word returns the new data: accesses are serialised, so there is no hazard.

## Test plan
- Reset with a request pending in WAIT (WAIT_STATES=3): pull `i_reset_n` low → outputs read 0 within the same cycle. Release and re-issue the request → a full response after 4 cycles.
- Write 32'hDEADBEEF, byteen 1111, at BASE_ADDR+0x10, then read the same address (WAIT_STATES=0) → each access gets `o_bus_ready` for one cycle, 1 cycle after accept, with err=0. Read returns 32'hDEADBEEF.
- Partial write to the same word: wdata 32'h0000AB00, byteen 0010 → a later read returns 32'hDEADABEF. Repeat with byteen 0000 → the word is unchanged and err=0.
- Write to BASE_ADDR+4*DEPTH_WORDS and to BASE_ADDR−4 → err=1 and ready=1 for each. A following read of word 0 shows the prior contents; a read of the out-of-range address returns rdata 0 with err=1.
- `we`=`re`=1 at BASE_ADDR → err=1 and no RAM change, confirmed by a readback.
- WAIT_STATES=3, requests held continuously → ready at the 4th cycle after each accept, and accepts spaced 5 cycles apart. Addresses with addr[1:0]=2'b11 and 2'b00 in the same word read identical data.
